// File: rtl/fetch_stage_utlb.sv
// fetch_stage_utlb: instruction-fetch request stage with a fully-associative
// micro-TLB. Hits and unmapped fetches issue in the same cycle; a micro-TLB
// miss walks CHK -> QRY -> REQ, querying the main TLB and caching the result.
// Optional build macro FETCH_PERFCNT_EN adds the two performance counters.
module fetch_stage_utlb #(
    parameter int UTLB_ENTRIES = 4,
    parameter int PERFCNT_W    = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    output logic                 inst_req,
    output logic                 inst_cache,
    output logic [31:0]          inst_addr,
    input  logic                 inst_addr_ok,
    input  logic                 tlb_write,
    output logic [31:0]          tlb_vaddr,
    input  logic [31:0]          tlb_paddr,
    input  logic                 tlb_miss,
    input  logic                 tlb_invalid,
    input  logic [2:0]           tlb_cattr,
    input  logic                 status_um,
    input  logic                 status_exl,
    input  logic [2:0]           config_k0,
    output logic                 ready_o,
    input  logic                 valid_i,
    input  logic [31:0]          pc_i,
    input  logic                 ready_i,
    output logic                 valid_o,
    output logic [31:0]          pc_o,
    output logic                 cancelled_o,
    output logic                 exc_o,
    output logic                 exc_miss_o,
    output logic [4:0]           exccode_o,
    input  logic                 commit_i,
    output logic [PERFCNT_W-1:0] perfcnt_fetch_waitreq,
    output logic [PERFCNT_W-1:0] perfcnt_utlb_miss
);
    localparam int IDX_W = (UTLB_ENTRIES > 1) ? $clog2(UTLB_ENTRIES) : 1;

    typedef enum logic [1:0] {CHK = 2'd0, QRY = 2'd1, REQ = 2'd2} state_t;

    state_t                         state_q, state_d;
    logic [31:0]                    pc_save_q, pc_save_d;
    logic [IDX_W-1:0]               rr_q, rr_d;
    logic [UTLB_ENTRIES-1:0]        ent_valid_q, ent_valid_d;
    logic [UTLB_ENTRIES-1:0][19:0]  vpn_q, vpn_d;
    logic [UTLB_ENTRIES-1:0][19:0]  ppn_q, ppn_d;
    logic [UTLB_ENTRIES-1:0][2:0]   cattr_q, cattr_d;
    logic [19:0]                    qppn_q, qppn_d;
    logic                           qmiss_q, qmiss_d;
    logic                           qinvalid_q, qinvalid_d;
    logic [2:0]                     qcattr_q, qcattr_d;
    logic                           valid_o_q, valid_o_d;
    logic [31:0]                    pc_o_q, pc_o_d;
    logic                           cancelled_o_q, cancelled_o_d;
    logic                           exc_o_q, exc_o_d;
    logic                           exc_miss_o_q, exc_miss_o_d;
    logic [4:0]                     exccode_o_q, exccode_o_d;

    logic              unmapped, kernel, adel, is_chk, is_req, fault, req_state;
    logic              hit, victim_found;
    logic [19:0]       hit_ppn;
    logic [2:0]        hit_cattr;
    logic [IDX_W-1:0]  victim;

    assign unmapped  = (pc_i[31:30] == 2'b10);
    assign kernel    = !status_um || status_exl;
    assign adel      = (pc_i[1:0] != 2'b00) || (pc_i[31] && !kernel);
    assign is_chk    = (state_q == CHK);
    assign is_req    = (state_q == REQ);
    assign fault     = (is_chk && adel) || (is_req && (qmiss_q || qinvalid_q));
    assign req_state = (is_chk && (unmapped || hit)) || is_req;
    assign inst_req  = valid_i && ready_i && !fault && req_state;
    assign ready_o   = ready_i && (inst_addr_ok || fault);
    assign tlb_vaddr = pc_save_q;

    // Associative lookup; at most one entry matches so OR-merging is exact.
    always_comb begin
        hit       = 1'b0;
        hit_ppn   = '0;
        hit_cattr = '0;
        for (int i = 0; i < UTLB_ENTRIES; i++) begin
            if (ent_valid_q[i] && (vpn_q[i] == pc_i[31:12])) begin
                hit       = 1'b1;
                hit_ppn   = hit_ppn | ppn_q[i];
                hit_cattr = hit_cattr | cattr_q[i];
            end
        end
    end

    // Victim choice: lowest-index free entry, else the round-robin pointer.
    always_comb begin
        victim       = rr_q;
        victim_found = 1'b0;
        for (int i = UTLB_ENTRIES - 1; i >= 0; i--) begin
            if (!ent_valid_q[i]) begin
                victim       = IDX_W'(i);
                victim_found = 1'b1;
            end
        end
    end

    // Physical address and cacheability of the request being issued.
    always_comb begin
        inst_addr  = 32'h0;
        inst_cache = 1'b0;
        if (is_chk && unmapped) begin
            inst_addr  = {3'b000, pc_i[28:0]};
            inst_cache = pc_i[29] ? 1'b0 : (config_k0 == 3'd3);
        end else if (is_chk && hit) begin
            inst_addr  = {hit_ppn, pc_i[11:0]};
            inst_cache = (hit_cattr == 3'd3);
        end else if (is_req) begin
            inst_addr  = {qppn_q, pc_save_q[11:0]};
            inst_cache = (qcattr_q == 3'd3);
        end
    end

    // Query FSM, micro-TLB fill and flush.
    always_comb begin
        state_d     = state_q;
        pc_save_d   = pc_save_q;
        rr_d        = rr_q;
        ent_valid_d = ent_valid_q;
        vpn_d       = vpn_q;
        ppn_d       = ppn_q;
        cattr_d     = cattr_q;
        qppn_d      = qppn_q;
        qmiss_d     = qmiss_q;
        qinvalid_d  = qinvalid_q;
        qcattr_d    = qcattr_q;
        case (state_q)
            CHK: begin
                if (valid_i && ready_i && !unmapped && !hit && !adel) begin
                    state_d   = QRY;
                    pc_save_d = pc_i;
                end
            end
            QRY: begin
                state_d    = REQ;
                qppn_d     = tlb_paddr[31:12];
                qmiss_d    = tlb_miss;
                qinvalid_d = tlb_invalid;
                qcattr_d   = tlb_cattr;
                // Faulting translations are never cached.
                if (!tlb_miss && !tlb_invalid) begin
                    ent_valid_d[victim] = 1'b1;
                    vpn_d[victim]       = pc_save_q[31:12];
                    ppn_d[victim]       = tlb_paddr[31:12];
                    cattr_d[victim]     = tlb_cattr;
                    if (!victim_found) begin
                        rr_d = (rr_q == IDX_W'(UTLB_ENTRIES - 1)) ? '0 : rr_q + 1'b1;
                    end
                end
            end
            REQ: begin
                if (inst_addr_ok || (ready_i && fault)) begin
                    state_d = CHK;
                end
            end
            default: state_d = CHK;
        endcase
        // A flush overrides a same-cycle fill; the query result stays usable.
        if (tlb_write || commit_i) begin
            ent_valid_d = '0;
        end
        if (commit_i) begin
            state_d   = CHK;
            pc_save_d = pc_save_q;
        end
    end

    // IF/ID pipeline register, advancing only when downstream accepts.
    always_comb begin
        valid_o_d     = valid_o_q;
        pc_o_d        = pc_o_q;
        cancelled_o_d = cancelled_o_q;
        exc_o_d       = exc_o_q;
        exc_miss_o_d  = exc_miss_o_q;
        exccode_o_d   = exccode_o_q;
        if (ready_i) begin
            valid_o_d     = (valid_i && inst_addr_ok) || fault;
            pc_o_d        = is_chk ? pc_i : pc_save_q;
            cancelled_o_d = commit_i;
            exc_o_d       = fault;
            exc_miss_o_d  = is_req && qmiss_q;
            exccode_o_d   = adel ? 5'd4 : 5'd2;
        end
    end

    // Control state and outputs, cleared by reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= CHK;
            pc_save_q     <= 32'h0;
            rr_q          <= '0;
            ent_valid_q   <= '0;
            valid_o_q     <= 1'b0;
            pc_o_q        <= 32'h0;
            cancelled_o_q <= 1'b0;
            exc_o_q       <= 1'b0;
            exc_miss_o_q  <= 1'b0;
            exccode_o_q   <= 5'd0;
        end else begin
            state_q       <= state_d;
            pc_save_q     <= pc_save_d;
            rr_q          <= rr_d;
            ent_valid_q   <= ent_valid_d;
            valid_o_q     <= valid_o_d;
            pc_o_q        <= pc_o_d;
            cancelled_o_q <= cancelled_o_d;
            exc_o_q       <= exc_o_d;
            exc_miss_o_q  <= exc_miss_o_d;
            exccode_o_q   <= exccode_o_d;
        end
    end

    // Entry payloads and query result; qualified by valid bits / FSM state.
    always_ff @(posedge clk) begin
        vpn_q      <= vpn_d;
        ppn_q      <= ppn_d;
        cattr_q    <= cattr_d;
        qppn_q     <= qppn_d;
        qmiss_q    <= qmiss_d;
        qinvalid_q <= qinvalid_d;
        qcattr_q   <= qcattr_d;
    end

    assign valid_o     = valid_o_q;
    assign pc_o        = pc_o_q;
    assign cancelled_o = cancelled_o_q;
    assign exc_o       = exc_o_q;
    assign exc_miss_o  = exc_miss_o_q;
    assign exccode_o   = exccode_o_q;

`ifdef FETCH_PERFCNT_EN
    logic [PERFCNT_W-1:0] waitreq_cnt_q, waitreq_cnt_d;
    logic [PERFCNT_W-1:0] umiss_cnt_q, umiss_cnt_d;

    // Free-running event counters, wrapping naturally.
    always_comb begin
        waitreq_cnt_d = waitreq_cnt_q;
        umiss_cnt_d   = umiss_cnt_q;
        if (valid_i && inst_req && !inst_addr_ok) begin
            waitreq_cnt_d = waitreq_cnt_q + 1'b1;
        end
        if (state_q == QRY) begin
            umiss_cnt_d = umiss_cnt_q + 1'b1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            waitreq_cnt_q <= '0;
            umiss_cnt_q   <= '0;
        end else begin
            waitreq_cnt_q <= waitreq_cnt_d;
            umiss_cnt_q   <= umiss_cnt_d;
        end
    end

    assign perfcnt_fetch_waitreq = waitreq_cnt_q;
    assign perfcnt_utlb_miss     = umiss_cnt_q;
`else
    assign perfcnt_fetch_waitreq = '0;
    assign perfcnt_utlb_miss     = '0;
`endif

endmodule

// File: tb/tb_fetch_stage_utlb.sv
// Testbench for fetch_stage_utlb: vector table for single-cycle CHK fetches,
// hand-written sequences for misses, faults, flush races and backpressure.
module tb_fetch_stage_utlb;
    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_cache, inst_addr_ok;
    logic [31:0] inst_addr;
    logic        tlb_write;
    logic [31:0] tlb_vaddr, tlb_paddr;
    logic        tlb_miss, tlb_invalid;
    logic [2:0]  tlb_cattr;
    logic        status_um, status_exl;
    logic [2:0]  config_k0;
    logic        ready_o, valid_i, ready_i;
    logic [31:0] pc_i, pc_o;
    logic        valid_o, cancelled_o, exc_o, exc_miss_o;
    logic [4:0]  exccode_o;
    logic        commit_i;
    logic [31:0] perfcnt_fetch_waitreq, perfcnt_utlb_miss;
    logic        mem_ok;

    int total = 0;
    int bad   = 0;

    fetch_stage_utlb #(.UTLB_ENTRIES(4), .PERFCNT_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_cache(inst_cache), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .tlb_write(tlb_write), .tlb_vaddr(tlb_vaddr),
        .tlb_paddr(tlb_paddr), .tlb_miss(tlb_miss), .tlb_invalid(tlb_invalid),
        .tlb_cattr(tlb_cattr), .status_um(status_um), .status_exl(status_exl),
        .config_k0(config_k0), .ready_o(ready_o), .valid_i(valid_i), .pc_i(pc_i),
        .ready_i(ready_i), .valid_o(valid_o), .pc_o(pc_o), .cancelled_o(cancelled_o),
        .exc_o(exc_o), .exc_miss_o(exc_miss_o), .exccode_o(exccode_o),
        .commit_i(commit_i), .perfcnt_fetch_waitreq(perfcnt_fetch_waitreq),
        .perfcnt_utlb_miss(perfcnt_utlb_miss)
    );

    always #5 clk = ~clk;

    // Memory accepts a request in the same cycle when mem_ok is set.
    assign inst_addr_ok = mem_ok & inst_req;

    // Main TLB model: page 0x00400 maps to 0x01234, others add 0x01000.
    function automatic logic [19:0] ref_ppn(input logic [19:0] vpn);
        return (vpn == 20'h00400) ? 20'h01234 : vpn + 20'h01000;
    endfunction
    assign tlb_paddr = {ref_ppn(tlb_vaddr[31:12]), tlb_vaddr[11:0]};

    typedef struct {
        logic [31:0] pc;
        logic        um, exl;
        logic [2:0]  k0;
        logic        req;
        logic [31:0] addr;
        logic        cache;
        logic        exc;
        logic [4:0]  code;
    } vec_t;
    vec_t vt[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0; valid_i = 1'b0; pc_i = 32'h0; ready_i = 1'b1;
        commit_i = 1'b0; tlb_write = 1'b0; mem_ok = 1'b1;
        tlb_miss = 1'b0; tlb_invalid = 1'b0; tlb_cattr = 3'd3;
        status_um = 1'b0; status_exl = 1'b0; config_k0 = 3'd3;
        cyc(); cyc();
        resetn = 1'b1;
    endtask

    // Full micro-TLB miss: CHK (no req), QRY, REQ (req), then IF/ID check.
    task automatic do_miss(input string name, input logic [31:0] pc,
                           input logic [31:0] exp_addr, input logic exp_cache);
        pc_i = pc; valid_i = 1'b1;
        #2;
        check({name, " chk_req"}, 32'(inst_req), 0);
        cyc();
        check({name, " qry_vaddr"}, tlb_vaddr, pc);
        check({name, " qry_req"}, 32'(inst_req), 0);
        cyc();
        check({name, " req_req"}, 32'(inst_req), 1);
        check({name, " req_addr"}, inst_addr, exp_addr);
        check({name, " req_cache"}, 32'(inst_cache), 32'(exp_cache));
        cyc();
        check({name, " valid_o"}, 32'(valid_o), 1);
        check({name, " pc_o"}, pc_o, pc);
        valid_i = 1'b0; pc_i = 32'h0;
    endtask

    // Same-cycle fetch from CHK (hit or unmapped).
    task automatic do_hit(input string name, input logic [31:0] pc,
                          input logic [31:0] exp_addr, input logic exp_cache);
        pc_i = pc; valid_i = 1'b1;
        #2;
        check({name, " req"}, 32'(inst_req), 1);
        check({name, " addr"}, inst_addr, exp_addr);
        check({name, " cache"}, 32'(inst_cache), 32'(exp_cache));
        cyc();
        check({name, " valid_o"}, 32'(valid_o), 1);
        check({name, " pc_o"}, pc_o, pc);
        valid_i = 1'b0; pc_i = 32'h0;
    endtask

    // Main-TLB fault on query: no request, exception reported from REQ.
    task automatic do_fault(input string name, input logic [31:0] pc, input logic miss);
        tlb_miss = miss; tlb_invalid = !miss;
        pc_i = pc; valid_i = 1'b1;
        cyc(); cyc();
        check({name, " req"}, 32'(inst_req), 0);
        check({name, " ready_o"}, 32'(ready_o), 1);
        cyc();
        check({name, " valid_o"}, 32'(valid_o), 1);
        check({name, " exc_o"}, 32'(exc_o), 1);
        check({name, " exc_miss_o"}, 32'(exc_miss_o), 32'(miss));
        check({name, " exccode_o"}, 32'(exccode_o), 2);
        check({name, " pc_o"}, pc_o, pc);
        tlb_miss = 1'b0; tlb_invalid = 1'b0;
        valid_i = 1'b0; pc_i = 32'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //            pc            um    exl   k0    req   addr          cache exc   code
        vt[0] = '{32'hBFC00000, 1'b0, 1'b0, 3'd3, 1'b1, 32'h1FC00000, 1'b0, 1'b0, 5'd2};
        vt[1] = '{32'h80001000, 1'b0, 1'b0, 3'd3, 1'b1, 32'h00001000, 1'b1, 1'b0, 5'd2};
        vt[2] = '{32'h80001000, 1'b0, 1'b0, 3'd2, 1'b1, 32'h00001000, 1'b0, 1'b0, 5'd2};
        vt[3] = '{32'h9FFFFFFC, 1'b0, 1'b0, 3'd3, 1'b1, 32'h1FFFFFFC, 1'b1, 1'b0, 5'd2};
        vt[4] = '{32'h80000000, 1'b1, 1'b0, 3'd3, 1'b0, 32'h00000000, 1'b0, 1'b1, 5'd4};
        vt[5] = '{32'h80000000, 1'b1, 1'b1, 3'd3, 1'b1, 32'h00000000, 1'b1, 1'b0, 5'd2};
        vt[6] = '{32'hBFC00002, 1'b0, 1'b0, 3'd3, 1'b0, 32'h00000000, 1'b0, 1'b1, 5'd4};
        vt[7] = '{32'h00400002, 1'b0, 1'b0, 3'd3, 1'b0, 32'h00000000, 1'b0, 1'b1, 5'd4};
        vt[8] = '{32'hA0000010, 1'b0, 1'b0, 3'd3, 1'b1, 32'h00000010, 1'b0, 1'b0, 5'd2};

        do_reset();
        check("rst valid_o", 32'(valid_o), 0);
        check("rst pc_o", pc_o, 0);
        check("rst exc_o", 32'(exc_o), 0);
        check("rst exc_miss_o", 32'(exc_miss_o), 0);
        check("rst exccode_o", 32'(exccode_o), 0);
        check("rst cancelled_o", 32'(cancelled_o), 0);
        check("rst tlb_vaddr", tlb_vaddr, 0);
        check("rst inst_req", 32'(inst_req), 0);
        check("rst waitreq", perfcnt_fetch_waitreq, 0);
        check("rst utlb_miss", perfcnt_utlb_miss, 0);

        // Single-cycle decode vectors; each leaves the FSM in CHK.
        for (int i = 0; i < 9; i++) begin
            pc_i = vt[i].pc; status_um = vt[i].um; status_exl = vt[i].exl;
            config_k0 = vt[i].k0; valid_i = 1'b1;
            #2;
            check($sformatf("vec%0d req", i), 32'(inst_req), 32'(vt[i].req));
            check($sformatf("vec%0d ready_o", i), 32'(ready_o), 1);
            if (vt[i].req) begin
                check($sformatf("vec%0d addr", i), inst_addr, vt[i].addr);
                check($sformatf("vec%0d cache", i), 32'(inst_cache), 32'(vt[i].cache));
            end
            cyc();
            check($sformatf("vec%0d valid_o", i), 32'(valid_o), 1);
            check($sformatf("vec%0d pc_o", i), pc_o, vt[i].pc);
            check($sformatf("vec%0d exc_o", i), 32'(exc_o), 32'(vt[i].exc));
            check($sformatf("vec%0d exccode", i), 32'(exccode_o), 32'(vt[i].code));
            check($sformatf("vec%0d exc_miss", i), 32'(exc_miss_o), 0);
        end
        valid_i = 1'b0; pc_i = 32'h0;
        status_um = 1'b0; status_exl = 1'b0; config_k0 = 3'd3;

        // Mapped miss, refill, then a hit on the same page.
        do_miss("refill", 32'h00400000, 32'h01234000, 1'b1);
        do_hit("rehit", 32'h00400010, 32'h01234010, 1'b1);

        // Faulting queries are reported and never cached.
        do_fault("tlbmiss", 32'h00500000, 1'b1);
        tlb_cattr = 3'd2;
        do_miss("after_miss", 32'h00500000, 32'h01500000, 1'b0);
        tlb_cattr = 3'd3;
        do_fault("tlbinv", 32'h00510000, 1'b0);

        // tlb_write during QRY: REQ still issues, but the fill is dropped.
        pc_i = 32'h00600000; valid_i = 1'b1;
        cyc();
        tlb_write = 1'b1;
        cyc();
        tlb_write = 1'b0;
        #2;
        check("wrflush req", 32'(inst_req), 1);
        check("wrflush addr", inst_addr, 32'h01600000);
        cyc();
        do_miss("wrflush again", 32'h00600004, 32'h01600004, 1'b1);

        // commit_i while waiting in REQ: back to CHK, cancel, flush all.
        pc_i = 32'h00700000; valid_i = 1'b1;
        cyc(); cyc();
        mem_ok = 1'b0; commit_i = 1'b1;
        #2;
        check("commit req", 32'(inst_req), 1);
        check("commit ready_o", 32'(ready_o), 0);
        cyc();
        commit_i = 1'b0; mem_ok = 1'b1;
        check("commit cancelled_o", 32'(cancelled_o), 1);
        check("commit valid_o", 32'(valid_o), 0);
        do_miss("commit refetch", 32'h00700000, 32'h01700000, 1'b1);
        check("commit cancel clr", 32'(cancelled_o), 0);
        do_miss("commit oldpage", 32'h00600008, 32'h01600008, 1'b1);

        // Reset during QRY discards the in-flight query.
        pc_i = 32'h00900000; valid_i = 1'b1;
        cyc();
        resetn = 1'b0;
        cyc();
        resetn = 1'b1;
        check("midrst valid_o", 32'(valid_o), 0);
        check("midrst tlb_vaddr", tlb_vaddr, 0);
        do_miss("midrst refetch", 32'h00900000, 32'h01900000, 1'b1);

        // Capacity: five pages into four entries, round-robin eviction.
        do_reset();
        do_miss("cap p1", 32'h00400000, 32'h01234000, 1'b1);
        do_miss("cap p2", 32'h00401000, 32'h01401000, 1'b1);
        do_miss("cap p3", 32'h00402000, 32'h01402000, 1'b1);
        do_miss("cap p4", 32'h00403000, 32'h01403000, 1'b1);
        do_miss("cap p5", 32'h00404000, 32'h01404000, 1'b1);
        do_hit("cap hit p2", 32'h00401020, 32'h01401020, 1'b1);
        do_hit("cap hit p3", 32'h00402020, 32'h01402020, 1'b1);
        do_hit("cap hit p4", 32'h00403020, 32'h01403020, 1'b1);
        do_hit("cap hit p5", 32'h00404020, 32'h01404020, 1'b1);
        do_miss("cap p1 again", 32'h00400000, 32'h01234000, 1'b1);
`ifdef FETCH_PERFCNT_EN
        check("cap utlb_miss", perfcnt_utlb_miss, 6);
`else
        check("cap utlb_miss", perfcnt_utlb_miss, 0);
`endif

        // Backpressure: ready_i low holds everything in CHK.
        do_reset();
        do_hit("bp pre", 32'hA0000100, 32'h00000100, 1'b0);
        ready_i = 1'b0; pc_i = 32'hBFC00000; valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            check($sformatf("bp%0d req", i), 32'(inst_req), 0);
            check($sformatf("bp%0d ready_o", i), 32'(ready_o), 0);
            cyc();
            check($sformatf("bp%0d pc_o", i), pc_o, 32'hA0000100);
            check($sformatf("bp%0d valid_o", i), 32'(valid_o), 1);
        end
        ready_i = 1'b1;
        do_hit("bp release", 32'hBFC00000, 32'h1FC00000, 1'b0);

        // inst_addr_ok withheld for two cycles in REQ.
        pc_i = 32'h00800000; valid_i = 1'b1;
        cyc(); cyc();
        mem_ok = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #2;
            check($sformatf("wait%0d req", i), 32'(inst_req), 1);
            check($sformatf("wait%0d ready_o", i), 32'(ready_o), 0);
            cyc();
        end
        mem_ok = 1'b1;
        #2;
        check("wait go req", 32'(inst_req), 1);
        check("wait go ready_o", 32'(ready_o), 1);
        check("wait go addr", inst_addr, 32'h01800000);
        cyc();
        check("wait valid_o", 32'(valid_o), 1);
        check("wait pc_o", pc_o, 32'h00800000);
        valid_i = 1'b0; pc_i = 32'h0;
`ifdef FETCH_PERFCNT_EN
        check("waitreq count", perfcnt_fetch_waitreq, 2);
        check("wait utlb_miss", perfcnt_utlb_miss, 1);
`else
        check("waitreq count", perfcnt_fetch_waitreq, 0);
        check("wait utlb_miss", perfcnt_utlb_miss, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
